// File: rtl/serial_fsm_arbiter.sv
// Round-robin scheduler sharing one serial bit-pattern FSM among NREQ requesters.
// Define SERIAL_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module serial_fsm_arbiter #(
  parameter int NREQ    = 4,
  parameter int FRAME_W = 8,
  parameter int LEN_W   = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*FRAME_W-1:0]  frame_data,
  input  logic [NREQ*LEN_W-1:0]    frame_len,
  output logic [NREQ-1:0]          grant,
  output logic                     done,
  output logic                     result,
  output logic                     busy,
  output logic                     fsm_in,
  output logic                     fsm_rst,
  input  logic                     fsm_out
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, SAMPLE, RESP} state_t;

  state_t               state_reg, state_next;
  logic [NREQ-1:0]      grant_reg, grant_next;
  logic                 done_reg, done_next;
  logic                 result_reg, result_next;
  logic                 busy_reg, busy_next;
  logic                 fsm_in_reg, fsm_in_next;
  logic                 fsm_rst_reg, fsm_rst_next;
  logic [FRAME_W-1:0]   shift_reg, shift_next;
  logic [LEN_W-1:0]     cnt_reg, cnt_next;
  logic                 len_zero_reg, len_zero_next;

  logic [PTR_W-1:0]     ptr;
  logic [PTR_W-1:0]     pick_idx;
  logic                 pick_found;
  int                   rr_idx;

  logic [FRAME_W-1:0]   frame_arr [NREQ];
  logic [LEN_W-1:0]     len_arr   [NREQ];

  // Per-requester views, with the length already clamped to FRAME_W
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign frame_arr[gi] = frame_data[gi*FRAME_W +: FRAME_W];
      assign len_arr[gi]   = (frame_len[gi*LEN_W +: LEN_W] > LEN_W'(FRAME_W)) ?
                             LEN_W'(FRAME_W) : frame_len[gi*LEN_W +: LEN_W];
    end
  endgenerate

`ifdef SERIAL_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [PTR_W-1:0] ptr_reg;
  logic [PTR_W-1:0] grant_idx;

  always_comb begin
    grant_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant_reg[k]) grant_idx = PTR_W'(k);
    end
  end

  // The just-served requester drops to lowest priority
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_reg <= '0;
    end else if (state_reg == RESP) begin
      ptr_reg <= (grant_idx == PTR_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  assign ptr = ptr_reg;
`endif

  // First set request at or after the pointer, wrapping modulo NREQ
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    rr_idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      rr_idx = int'(ptr) + k;
      if (rr_idx >= NREQ) rr_idx = rr_idx - NREQ;
      if (!pick_found && req[rr_idx[PTR_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = rr_idx[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    done_next     = 1'b0;
    result_next   = result_reg;
    fsm_in_next   = 1'b0;
    fsm_rst_next  = fsm_rst_reg;
    shift_next    = shift_reg;
    cnt_next      = cnt_reg;
    len_zero_next = len_zero_reg;

    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          state_next    = CLEAR;
          grant_next    = NREQ'(1) << pick_idx;
          shift_next    = frame_arr[pick_idx];
          cnt_next      = len_arr[pick_idx];
          len_zero_next = (len_arr[pick_idx] == '0);
          fsm_rst_next  = 1'b1;
        end
      end
      CLEAR: begin
        if (len_zero_reg) begin
          state_next = SAMPLE;
        end else begin
          state_next   = SHIFT;
          fsm_rst_next = 1'b0;
          fsm_in_next  = shift_reg[0];
          shift_next   = shift_reg >> 1;
        end
      end
      SHIFT: begin
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg == LEN_W'(1)) begin
          state_next = SAMPLE;
        end else begin
          fsm_in_next = shift_reg[0];
          shift_next  = shift_reg >> 1;
        end
      end
      SAMPLE: begin
        state_next  = RESP;
        done_next   = 1'b1;
        result_next = len_zero_reg ? 1'b0 : fsm_out;
      end
      RESP: begin
        state_next   = IDLE;
        grant_next   = '0;
        fsm_rst_next = 1'b1;
      end
      default: begin
        state_next   = IDLE;
        grant_next   = '0;
        fsm_rst_next = 1'b1;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      grant_reg    <= '0;
      done_reg     <= 1'b0;
      result_reg   <= 1'b0;
      busy_reg     <= 1'b0;
      fsm_in_reg   <= 1'b0;
      fsm_rst_reg  <= 1'b1;
      shift_reg    <= '0;
      cnt_reg      <= '0;
      len_zero_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      done_reg     <= done_next;
      result_reg   <= result_next;
      busy_reg     <= busy_next;
      fsm_in_reg   <= fsm_in_next;
      fsm_rst_reg  <= fsm_rst_next;
      shift_reg    <= shift_next;
      cnt_reg      <= cnt_next;
      len_zero_reg <= len_zero_next;
    end
  end

  assign grant   = grant_reg;
  assign done    = done_reg;
  assign result  = result_reg;
  assign busy    = busy_reg;
  assign fsm_in  = fsm_in_reg;
  assign fsm_rst = fsm_rst_reg;

endmodule

// File: tb/tb_serial_fsm_arbiter.sv
// Directed bench for serial_fsm_arbiter with a small A/B/C "01" detector as the shared FSM.
// Honours SERIAL_ARB_FIXED_PRIO_EN for the arbitration expectations.
module tb_serial_fsm_arbiter;

  logic        clock;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] frame_data;
  logic [15:0] frame_len;
  logic [3:0]  grant;
  logic        done;
  logic        result;
  logic        busy;
  logic        fsm_in;
  logic        fsm_rst;
  logic        fsm_out;

  int passed = 0;
  int total  = 0;

  serial_fsm_arbiter #(.NREQ(4), .FRAME_W(8), .LEN_W(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .frame_data (frame_data),
    .frame_len  (frame_len),
    .grant      (grant),
    .done       (done),
    .result     (result),
    .busy       (busy),
    .fsm_in     (fsm_in),
    .fsm_rst    (fsm_rst),
    .fsm_out    (fsm_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Shared FSM: A -0-> B, A -1-> A, B -0-> B, B -1-> C, C -0-> B, C -1-> A; out=1 in C
  logic [1:0] fsm_st = 2'd0;
  always @(posedge clock) begin
    if (fsm_rst) fsm_st <= 2'd0;
    else begin
      case (fsm_st)
        2'd0:    fsm_st <= fsm_in ? 2'd0 : 2'd1;
        2'd1:    fsm_st <= fsm_in ? 2'd2 : 2'd1;
        default: fsm_st <= fsm_in ? 2'd0 : 2'd1;
      endcase
    end
  end
  assign fsm_out = (fsm_st == 2'd2);

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Call with inputs set while the DUT is idle; returns 1ns after the RESP->IDLE edge.
  task automatic run_txn(input string tag, input logic [3:0] g, input logic [7:0] fr,
                         input int len, input logic res, input bit perturb);
    tick;
    check({tag, " clear grant"}, 32'(grant), 32'(g));
    check({tag, " clear busy"}, 32'(busy), 32'd1);
    check({tag, " clear rst"}, 32'(fsm_rst), 32'd1);
    if (perturb) req = 4'b0000;
    for (int i = 0; i < len; i++) begin
      tick;
      if (perturb && i == 1) frame_data[7:0] = 8'h00;
      check($sformatf("%s shift%0d in", tag, i), 32'(fsm_in), 32'(fr[i]));
      check($sformatf("%s shift%0d rst", tag, i), 32'(fsm_rst), 32'd0);
      check($sformatf("%s shift%0d done", tag, i), 32'(done), 32'd0);
    end
    tick;
    check({tag, " sample in"}, 32'(fsm_in), 32'd0);
    check({tag, " sample done"}, 32'(done), 32'd0);
    check({tag, " sample rst"}, 32'(fsm_rst), (len == 0) ? 32'd1 : 32'd0);
    tick;
    check({tag, " resp done"}, 32'(done), 32'd1);
    check({tag, " resp result"}, 32'(result), 32'(res));
    check({tag, " resp grant"}, 32'(grant), 32'(g));
    tick;
    check({tag, " idle done"}, 32'(done), 32'd0);
    check({tag, " idle grant"}, 32'(grant), 32'd0);
    check({tag, " idle busy"}, 32'(busy), 32'd0);
    check({tag, " idle rst"}, 32'(fsm_rst), 32'd1);
    check({tag, " result held"}, 32'(result), 32'(res));
    $display("txn %s grant=%b len=%0d result=%b", tag, g, len, res);
  endtask

  logic [3:0] rr_g  [5];
  logic [7:0] rr_fr [5];
  logic       rr_r  [5];
  logic [3:0] ab_g  [3];

  initial begin
`ifdef SERIAL_ARB_FIXED_PRIO_EN
    rr_g  = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    rr_fr = '{8'h02, 8'h02, 8'h02, 8'h02, 8'h02};
    rr_r  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    ab_g  = '{4'b0010, 4'b0010, 4'b0010};
`else
    rr_g  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rr_fr = '{8'h02, 8'h01, 8'h02, 8'h03, 8'h02};
    rr_r  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    ab_g  = '{4'b0010, 4'b1000, 4'b0010};
`endif

    reset = 1'b0; req = 4'b0000; frame_data = '0; frame_len = '0;
    repeat (2) tick;
    check("reset grant", 32'(grant), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", 32'(result), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset fsm_in", 32'(fsm_in), 32'd0);
    check("reset fsm_rst", 32'(fsm_rst), 32'd1);
    reset = 1'b1;
    tick;
    check("idle fsm_rst", 32'(fsm_rst), 32'd1);
    check("idle busy", 32'(busy), 32'd0);

    // Round-robin with all requests held, length 2
    frame_data = {8'h03, 8'h02, 8'h01, 8'h02};
    frame_len  = {4'd2, 4'd2, 4'd2, 4'd2};
    req = 4'b1111;
    for (int i = 0; i < 5; i++) run_txn($sformatf("rr%0d", i), rr_g[i], rr_fr[i], 2, rr_r[i], 1'b0);
    req = 4'b0000;

    // Single request, full 8-bit frame ending in C
    frame_data[7:0] = 8'h80; frame_len[3:0] = 4'd8; req = 4'b0001;
    run_txn("single", 4'b0001, 8'h80, 8, 1'b1, 1'b0);
    req = 4'b0000;

    // Zero length: no shift, result forced 0
    frame_data[23:16] = 8'h02; frame_len[11:8] = 4'd0; req = 4'b0100;
    run_txn("len0", 4'b0100, 8'h02, 0, 1'b0, 1'b0);
    req = 4'b0000;

    // Oversized length clamps to 8 shift cycles
    frame_data[31:24] = 8'h80; frame_len[15:12] = 4'd12; req = 4'b1000;
    run_txn("len12", 4'b1000, 8'h80, 8, 1'b1, 1'b0);
    req = 4'b0000;

    // Reset during the third shift cycle
    frame_data[15:8] = 8'hFF; frame_len[7:4] = 4'd8; req = 4'b0010;
    repeat (4) tick;
    check("midrst pre busy", 32'(busy), 32'd1);
    check("midrst pre in", 32'(fsm_in), 32'd1);
    reset = 1'b0;
    #1;
    check("midrst grant", 32'(grant), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst fsm_rst", 32'(fsm_rst), 32'd1);
    check("midrst fsm_in", 32'(fsm_in), 32'd0);
    req = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick;
      check($sformatf("midrst nodone%0d", i), 32'(done), 32'd0);
    end
    reset = 1'b1;
    req = 4'b0001;
    run_txn("postrst", 4'b0001, 8'h80, 8, 1'b1, 1'b0);
    req = 4'b0000;

    // Request drop after grant and frame change mid-shift are ignored
    frame_data[7:0] = 8'h08; frame_len[3:0] = 4'd4; req = 4'b0001;
    run_txn("drop", 4'b0001, 8'h08, 4, 1'b1, 1'b1);
    req = 4'b0000;

    // Requesters 1 and 3 held: rotation vs fixed priority
    frame_len[7:4] = 4'd0; frame_len[15:12] = 4'd0; req = 4'b1010;
    for (int i = 0; i < 3; i++) run_txn($sformatf("ab%0d", i), ab_g[i], 8'h00, 0, 1'b0, 1'b0);
    req = 4'b0000;
    tick;
    check("final busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
